argmax_sequencer: RTL and testbench
===================================

Name: argmax_sequencer

Overview:
- Streaming controller for the classifier output stage. Scores arrive one per cycle through a valid/ready handshake.
- It tracks the running maximum score and its index, then presents the winning class index as a registered, held result.
- It is the sequential replacement for the flat all-scores-at-once argmax: it frames, counts, checks and hands off results to the downstream consumer.

Parameters:
- VALUES, 3, number of class scores per frame (>=1).
- DATA_SIZE, 8, score width in bits; scores are two's-complement signed.
- IDX_W, (VALUES>1 ? $clog2(VALUES) : 1), index width; derived, do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort; drops the frame and any pending result.
- s_valid  input  1  score beat valid.
- s_ready  output  1  block can accept a beat.
- s_data  input  DATA_SIZE  signed score.
- s_last  input  1  final beat of the frame.
- m_valid  output  1  result valid.
- m_ready  input  1  consumer accepts the result.
- m_index  output  IDX_W  winning class index.
- m_score  output  DATA_SIZE  winning score, signed.
- m_error  output  1  frame length mismatch flag.
- busy  output  1  frame in progress (state ACCUM).

Behaviour:
- Clock and reset: one clock (clk); rst_n is asynchronous assert and active-low.
- Reset values: state=IDLE, s_ready=1, m_valid=0, m_index=0, m_score=0, m_error=0, busy=0, beat counter=0.
- Beat acceptance: a beat is accepted when s_valid && s_ready at a rising clk.
- State IDLE (s_ready=1):
  - An accepted beat loads max=s_data, idx=0, cnt=1.
  - It then goes to ACCUM, or to DONE if it terminates the frame.
- State ACCUM (s_ready=1, busy=1):
  - For an accepted beat, if s_data > max (signed, strict), then max=s_data and idx=cnt.
  - Ties keep the lower index; cnt increments.
- Frame termination: the beat with s_last=1, or the beat at position VALUES-1, whichever comes first.
  - On termination go to DONE.
  - m_error=1 if s_last was seen at position != VALUES-1 (early last).
  - m_error=1 if position VALUES-1 arrived with s_last=0 (missing last).
  - Otherwise m_error=0.
- Single-beat frames: VALUES=1 terminates on the first beat.
- Latency: m_valid rises on the clk edge after the terminating beat is accepted, i.e. one cycle. The comparison uses the terminating beat.
- State DONE (s_ready=0):
  - m_index, m_score and m_error are registered and held stable while m_valid=1 && !m_ready.
  - On m_valid && m_ready: m_valid=0, go to IDLE; s_ready=1 from the next cycle.
  - There is no same-cycle bypass from the result handshake to a new beat.
- clear: has priority over all handshakes in every state.
  - The next state is IDLE with m_valid=0, m_error=0, cnt=0.
  - Any beat presented in that cycle is discarded.
  - m_index and m_score keep their last values but are meaningless.
- Reset mid-frame: the frame is lost and all outputs take their reset values immediately (asynchronously).
- Counter: cnt is IDX_W+1 bits and never wraps, because termination at VALUES-1 is forced.
- Outputs are fully registered: no combinational path from s_* or m_ready to m_*.
- s_ready is a decode of state only.

Optional Feature:
- Macro: ARGMAX_MARGIN_EN.
- Defined: add output m_margin, DATA_SIZE+1 bits unsigned, equal to max minus second-best score (full precision, no overflow).
  - Second-best is tracked per beat; when a new max is taken, the old max becomes second-best.
  - A tie with max sets the margin to 0.
  - A one-beat frame gives m_margin=0.
  - m_margin resets to 0, is registered with the other results and is held under backpressure.
- Undefined: the port and the second-best register are absent; all other behaviour is identical.

Test Plan:
- Scores 5, -3, 12 (s_last on third), m_ready=1 -> m_valid one cycle after beat 3, m_index=2, m_score=12, m_error=0; with margin: m_margin=7.
- Scores 7, 7, 2 -> m_index=0, m_score=7 (lower index wins the tie); margin: 0.
- Scores -128, -1, -5 -> m_index=1, m_score=-1 (all-negative frame is handled, no zero floor); margin: 4.
- Scores 3, 9, 1 with m_ready=0 for 4 cycles -> s_ready=0 and m_index=1/m_score=9 stable throughout; after handshake, s_ready=1 next cycle and the next frame 0, 0, 4 gives index 2.
- Length errors:
  - s_last on beat 1 (scores 2, 6) -> m_index=1, m_score=6, m_error=1.
  - Scores 1, 2, 3 with no s_last -> terminates after beat 3, m_index=2, m_error=1.
- Abort and reset:
  - clear pulsed after beat 2 of 9, 1, 4 -> m_valid stays 0; next frame -2, -7, -9 gives m_index=0, m_error=0.
  - rst_n low mid-frame -> all outputs at reset values immediately.

Source files
------------

// File: rtl/argmax_sequencer.sv
// rtl/argmax_sequencer.sv - streaming argmax over one frame of signed class scores
//
// Purpose: accepts VALUES signed scores per frame over a valid/ready stream,
// tracks the running maximum and its index, and presents the winning index and
// score as a registered result. The result is held until the consumer accepts it.
// Optional macro ARGMAX_MARGIN_EN adds m_margin, which is max minus second-best.
//
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   clear         synchronous abort: drops the current frame and any pending result
//   s_valid/s_ready/s_data/s_last   score stream in (s_data is signed)
//   m_valid/m_ready                 result handshake
//   m_index, m_score, m_error       winning index, winning score, frame-length error
//   busy          high while a frame is being accumulated
//   m_margin      (ARGMAX_MARGIN_EN only) max minus second-best, unsigned DATA_SIZE+1 bits
module argmax_sequencer #(
  parameter int VALUES    = 3,
  parameter int DATA_SIZE = 8,
  parameter int IDX_W     = (VALUES > 1) ? $clog2(VALUES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_SIZE-1:0] s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [IDX_W-1:0]     m_index,
  output logic [DATA_SIZE-1:0] m_score,
  output logic                 m_error,
  output logic                 busy
`ifdef ARGMAX_MARGIN_EN
  ,
  output logic [DATA_SIZE:0]   m_margin
`endif
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(VALUES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic signed [DATA_SIZE-1:0]  max_q, max_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         err_q, err_d;

`ifdef ARGMAX_MARGIN_EN
  logic signed [DATA_SIZE-1:0]  sec_q, sec_d;
  logic                         has_sec_q, has_sec_d;
  logic [DATA_SIZE:0]           margin_q, margin_d;
`endif

  logic                         accept;
  logic [CNT_W-1:0]             pos;
  logic                         at_end;
  logic                         take;
  logic signed [DATA_SIZE-1:0]  s_score;

  assign s_score = $signed(s_data);

  // Handshake-facing outputs are pure decodes of the state register.
  assign s_ready = (state_q != ST_DONE);
  assign m_valid = (state_q == ST_DONE);
  assign busy    = (state_q == ST_ACCUM);
  assign m_index = idx_q;
  assign m_score = max_q;
  assign m_error = err_q;
`ifdef ARGMAX_MARGIN_EN
  assign m_margin = margin_q;
`endif

  // Position of the beat currently presented; the first beat of a frame is 0.
  assign pos    = (state_q == ST_IDLE) ? '0 : cnt_q;
  assign at_end = (pos == LAST_POS);
  assign accept = s_valid && s_ready;
  // The first beat always seeds the maximum; later beats need a strict win so
  // ties keep the lower index.
  assign take   = (state_q == ST_IDLE) || (s_score > max_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    idx_d   = idx_q;
    err_d   = err_q;
`ifdef ARGMAX_MARGIN_EN
    sec_d     = sec_q;
    has_sec_d = has_sec_q;
    margin_d  = margin_q;
`endif

    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      err_d   = 1'b0;
`ifdef ARGMAX_MARGIN_EN
      has_sec_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            if (take) begin
              max_d = s_score;
              idx_d = IDX_W'(pos);
            end
            cnt_d = pos + CNT_W'(1);
`ifdef ARGMAX_MARGIN_EN
            if (state_q == ST_IDLE) begin
              has_sec_d = 1'b0;
            end else if (take) begin
              // Displaced maximum becomes the runner-up.
              sec_d     = max_q;
              has_sec_d = 1'b1;
            end else if (!has_sec_q || (s_score > sec_q)) begin
              // A tie with max lands here too, which gives a zero margin.
              sec_d     = s_score;
              has_sec_d = 1'b1;
            end
`endif
            if (s_last || at_end) begin
              state_d = ST_DONE;
              // Early last or missing last: the two flags disagree exactly on error.
              err_d   = s_last ^ at_end;
`ifdef ARGMAX_MARGIN_EN
              margin_d = has_sec_d
                       ? ({max_d[DATA_SIZE-1], max_d} - {sec_d[DATA_SIZE-1], sec_d})
                       : '0;
`endif
            end else begin
              state_d = ST_ACCUM;
            end
          end
        end
        ST_DONE: begin
          if (m_ready) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
      sec_q     <= '0;
      has_sec_q <= 1'b0;
      margin_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
`ifdef ARGMAX_MARGIN_EN
      sec_q     <= sec_d;
      has_sec_q <= has_sec_d;
      margin_q  <= margin_d;
`endif
    end
  end

endmodule

// File: tb/tb_argmax_sequencer.sv
// tb/tb_argmax_sequencer.sv - directed scoreboard bench for argmax_sequencer
module tb_argmax_sequencer;

  localparam int VALUES    = 3;
  localparam int DATA_SIZE = 8;
  localparam int IDX_W     = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 clear;
  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_SIZE-1:0] s_data;
  logic                 s_last;
  logic                 m_valid;
  logic                 m_ready;
  logic [IDX_W-1:0]     m_index;
  logic [DATA_SIZE-1:0] m_score;
  logic                 m_error;
  logic                 busy;
`ifdef ARGMAX_MARGIN_EN
  logic [DATA_SIZE:0]   m_margin;
`endif

  typedef struct {
    logic [IDX_W-1:0]     idx;
    logic [DATA_SIZE-1:0] score;
    logic                 err;
    logic [DATA_SIZE:0]   margin;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  argmax_sequencer #(
    .VALUES   (VALUES),
    .DATA_SIZE(DATA_SIZE)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_index (m_index),
    .m_score (m_score),
    .m_error (m_error),
    .busy    (busy)
`ifdef ARGMAX_MARGIN_EN
    ,
    .m_margin(m_margin)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int idx, input int score, input bit err, input int margin);
    exp_t e;
    e.idx    = IDX_W'(idx);
    e.score  = DATA_SIZE'(score);
    e.err    = err;
    e.margin = (DATA_SIZE + 1)'(margin);
    sb.push_back(e);
  endtask

  task automatic beat(input int data, input bit last);
    s_valid = 1'b1;
    s_data  = DATA_SIZE'(data);
    s_last  = last;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " s_ready"}, 32'(s_ready), 1);
    chk({tag, " m_valid"}, 32'(m_valid), 0);
    chk({tag, " m_index"}, 32'(m_index), 0);
    chk({tag, " m_score"}, 32'(m_score), 0);
    chk({tag, " m_error"}, 32'(m_error), 0);
    chk({tag, " busy"},    32'(busy), 0);
`ifdef ARGMAX_MARGIN_EN
    chk({tag, " m_margin"}, 32'(m_margin), 0);
`endif
  endtask

  // Called right after the terminating beat; the result must already be
  // visible at the next falling edge.
  task automatic expect_result(input string tag);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    while (m_valid !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, " latency"}, 32'(waited), 0);
    if (m_valid === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " m_index"}, 32'(m_index), 32'(e.idx));
      chk({tag, " m_score"}, 32'(m_score), 32'(e.score));
      chk({tag, " m_error"}, 32'(m_error), 32'(e.err));
      chk({tag, " s_ready"}, 32'(s_ready), 0);
`ifdef ARGMAX_MARGIN_EN
      chk({tag, " m_margin"}, 32'(m_margin), 32'(e.margin));
`endif
    end else begin
      chk({tag, " result present"}, 32'(m_valid), 1);
    end
  endtask

  // With m_ready high, the handshake completes on the next rising edge.
  task automatic finish_handshake(input string tag);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({tag, " m_valid after ack"}, 32'(m_valid), 0);
    chk({tag, " s_ready after ack"}, 32'(s_ready), 1);
  endtask

  initial begin
    rst_n   = 1'b0;
    clear   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);

    // 5, -3, 12
    push_exp(2, 12, 1'b0, 7);
    beat(5, 1'b0);
    chk("f1 busy", 32'(busy), 1);
    beat(-3, 1'b0);
    chk("f1 m_valid before last", 32'(m_valid), 0);
    beat(12, 1'b1);
    expect_result("f1");
    finish_handshake("f1");

    // Tie keeps the lower index
    push_exp(0, 7, 1'b0, 0);
    beat(7, 1'b0);
    beat(7, 1'b0);
    beat(2, 1'b1);
    expect_result("f2");
    finish_handshake("f2");

    // All-negative frame
    push_exp(1, -1, 1'b0, 4);
    beat(-128, 1'b0);
    beat(-1, 1'b0);
    beat(-5, 1'b1);
    expect_result("f3");
    finish_handshake("f3");

    // Backpressure: result held for 4 cycles
    m_ready = 1'b0;
    push_exp(1, 9, 1'b0, 6);
    beat(3, 1'b0);
    beat(9, 1'b0);
    beat(1, 1'b1);
    expect_result("f4");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("f4 hold m_valid", 32'(m_valid), 1);
      chk("f4 hold s_ready", 32'(s_ready), 0);
      chk("f4 hold m_index", 32'(m_index), 1);
      chk("f4 hold m_score", 32'(m_score), 9);
    end
    m_ready = 1'b1;
    finish_handshake("f4");

    push_exp(2, 4, 1'b0, 4);
    beat(0, 1'b0);
    beat(0, 1'b0);
    beat(4, 1'b1);
    expect_result("f5");
    finish_handshake("f5");

    // Early last
    push_exp(1, 6, 1'b1, 4);
    beat(2, 1'b0);
    beat(6, 1'b1);
    expect_result("early_last");
    finish_handshake("early_last");

    // Missing last
    push_exp(2, 3, 1'b1, 1);
    beat(1, 1'b0);
    beat(2, 1'b0);
    beat(3, 1'b0);
    expect_result("missing_last");
    finish_handshake("missing_last");

    // clear after two beats; the beat offered with clear is dropped
    beat(9, 1'b0);
    beat(1, 1'b0);
    clear   = 1'b1;
    s_valid = 1'b1;
    s_data  = DATA_SIZE'(4);
    s_last  = 1'b1;
    @(posedge clk);
    #1;
    clear   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("clear m_valid", 32'(m_valid), 0);
      chk("clear busy", 32'(busy), 0);
    end
    push_exp(0, -2, 1'b0, 5);
    beat(-2, 1'b0);
    beat(-7, 1'b0);
    beat(-9, 1'b1);
    expect_result("after_clear");
    finish_handshake("after_clear");

    // Asynchronous reset in the middle of a frame
    beat(50, 1'b0);
    beat(60, 1'b0);
    chk("pre_reset busy", 32'(busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_reset");

    chk("scoreboard empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
